// File: rtl/alu_rs_scheduler_if.sv
// alu_rs_scheduler_if: dispatch, CDB snoop and ALU issue bundle for the ALU reservation station
interface alu_rs_scheduler_if #(
    parameter int TAG_W  = 4,
    parameter int INST_W = 6,
    parameter int XLEN   = 32
);
    logic              disp_valid;
    logic [INST_W-1:0] disp_inst;
    logic [XLEN-1:0]   disp_npc;
    logic [XLEN-1:0]   disp_imme;
    logic [TAG_W-1:0]  disp_dest;
    logic [XLEN-1:0]   disp_vj;
    logic [XLEN-1:0]   disp_vk;
    logic [TAG_W-1:0]  disp_qj;
    logic [TAG_W-1:0]  disp_qk;
    logic [TAG_W-1:0]  cdb_alu_tag;
    logic [XLEN-1:0]   cdb_alu_val;
    logic [TAG_W-1:0]  cdb_lsb_tag;
    logic [XLEN-1:0]   cdb_lsb_val;
    logic              rs_full;
    logic [INST_W-1:0] alu_inst;
    logic [XLEN-1:0]   alu_npc;
    logic [XLEN-1:0]   alu_rs1_val;
    logic [XLEN-1:0]   alu_rs2_val;
    logic [XLEN-1:0]   alu_imme;
    logic [TAG_W-1:0]  alu_tag;

    modport master (
        output disp_valid, disp_inst, disp_npc, disp_imme, disp_dest,
               disp_vj, disp_vk, disp_qj, disp_qk,
               cdb_alu_tag, cdb_alu_val, cdb_lsb_tag, cdb_lsb_val,
        input  rs_full, alu_inst, alu_npc, alu_rs1_val, alu_rs2_val, alu_imme, alu_tag
    );

    modport slave (
        input  disp_valid, disp_inst, disp_npc, disp_imme, disp_dest,
               disp_vj, disp_vk, disp_qj, disp_qk,
               cdb_alu_tag, cdb_alu_val, cdb_lsb_tag, cdb_lsb_val,
        output rs_full, alu_inst, alu_npc, alu_rs1_val, alu_rs2_val, alu_imme, alu_tag
    );
endinterface

// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: ALU reservation station holding ops until operands resolve, issuing one per cycle
module alu_rs_scheduler #(
    parameter int RS_DEPTH = 16,
    parameter int TAG_W    = 4,
    parameter int INST_W   = 6,
    parameter int XLEN     = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    alu_rs_scheduler_if.slave bus
);
    localparam int IW = $clog2(RS_DEPTH);
    localparam int CW = $clog2(RS_DEPTH + 1);

    logic              r_busy [RS_DEPTH];
    logic [INST_W-1:0] r_inst [RS_DEPTH];
    logic [XLEN-1:0]   r_npc  [RS_DEPTH];
    logic [XLEN-1:0]   r_imme [RS_DEPTH];
    logic [TAG_W-1:0]  r_dest [RS_DEPTH];
    logic [XLEN-1:0]   r_vj   [RS_DEPTH];
    logic [XLEN-1:0]   r_vk   [RS_DEPTH];
    logic [TAG_W-1:0]  r_qj   [RS_DEPTH];
    logic [TAG_W-1:0]  r_qk   [RS_DEPTH];
    logic [CW-1:0]     r_count;

    logic [INST_W-1:0] r_alu_inst;
    logic [XLEN-1:0]   r_alu_npc;
    logic [XLEN-1:0]   r_alu_rs1;
    logic [XLEN-1:0]   r_alu_rs2;
    logic [XLEN-1:0]   r_alu_imme;
    logic [TAG_W-1:0]  r_alu_tag;

    logic              w_full;
    logic              w_free_hit;
    logic              w_rdy_hit;
    logic [IW-1:0]     w_free_idx;
    logic [IW-1:0]     w_rdy_idx;
    logic              w_accept;
    logic              w_go;
    logic              w_j_alu;
    logic              w_j_lsb;
    logic              w_k_alu;
    logic              w_k_lsb;
    logic [TAG_W-1:0]  w_qj;
    logic [TAG_W-1:0]  w_qk;
    logic [XLEN-1:0]   w_vj;
    logic [XLEN-1:0]   w_vk;

    assign w_full   = r_count == CW'(RS_DEPTH);
    assign w_accept = bus.disp_valid && !w_full && w_free_hit;
    assign w_go     = w_rdy_hit && !clear_in;

    assign w_j_alu = bus.disp_qj != '0 && bus.disp_qj == bus.cdb_alu_tag;
    assign w_j_lsb = bus.disp_qj != '0 && bus.disp_qj == bus.cdb_lsb_tag;
    assign w_k_alu = bus.disp_qk != '0 && bus.disp_qk == bus.cdb_alu_tag;
    assign w_k_lsb = bus.disp_qk != '0 && bus.disp_qk == bus.cdb_lsb_tag;
    assign w_qj    = (w_j_alu || w_j_lsb) ? '0 : bus.disp_qj;
    assign w_qk    = (w_k_alu || w_k_lsb) ? '0 : bus.disp_qk;
    assign w_vj    = w_j_alu ? bus.cdb_alu_val : w_j_lsb ? bus.cdb_lsb_val : bus.disp_vj;
    assign w_vk    = w_k_alu ? bus.cdb_alu_val : w_k_lsb ? bus.cdb_lsb_val : bus.disp_vk;

    assign bus.rs_full     = w_full;
    assign bus.alu_inst    = r_alu_inst;
    assign bus.alu_npc     = r_alu_npc;
    assign bus.alu_rs1_val = r_alu_rs1;
    assign bus.alu_rs2_val = r_alu_rs2;
    assign bus.alu_imme    = r_alu_imme;
    assign bus.alu_tag     = r_alu_tag;

    // Lowest free slot for dispatch and lowest ready slot for issue, both from registered state
    always_comb begin
        w_free_hit = 1'b0;
        w_free_idx = '0;
        w_rdy_hit  = 1'b0;
        w_rdy_idx  = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_hit = 1'b1;
                w_free_idx = IW'(i);
            end
            if (r_busy[i] && r_qj[i] == '0 && r_qk[i] == '0) begin
                w_rdy_hit = 1'b1;
                w_rdy_idx = IW'(i);
            end
        end
    end

    // Busy bits and occupancy; a slot freed by issue only becomes visible to dispatch next cycle
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_DEPTH; i++) r_busy[i] <= 1'b0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                for (int i = 0; i < RS_DEPTH; i++) r_busy[i] <= 1'b0;
                r_count <= '0;
            end else begin
                if (w_rdy_hit) r_busy[w_rdy_idx] <= 1'b0;
                if (w_accept) r_busy[w_free_idx] <= 1'b1;
                r_count <= r_count + CW'(w_accept) - CW'(w_rdy_hit);
            end
        end
    end

    // Static payload captured once at dispatch
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_inst[i] <= '0;
                r_npc[i]  <= '0;
                r_imme[i] <= '0;
                r_dest[i] <= '0;
            end
        end else if (rdy_in && !clear_in && w_accept) begin
            r_inst[w_free_idx] <= bus.disp_inst;
            r_npc[w_free_idx]  <= bus.disp_npc;
            r_imme[w_free_idx] <= bus.disp_imme;
            r_dest[w_free_idx] <= bus.disp_dest;
        end
    end

    // Operand capture: CDB wakeup of waiting entries (ALU bus first), then dispatch write with bypass
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_vj[i] <= '0;
                r_vk[i] <= '0;
                r_qj[i] <= '0;
                r_qk[i] <= '0;
            end
        end else if (rdy_in && !clear_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (r_busy[i] && r_qj[i] != '0 && r_qj[i] == bus.cdb_alu_tag) begin
                    r_vj[i] <= bus.cdb_alu_val;
                    r_qj[i] <= '0;
                end else if (r_busy[i] && r_qj[i] != '0 && r_qj[i] == bus.cdb_lsb_tag) begin
                    r_vj[i] <= bus.cdb_lsb_val;
                    r_qj[i] <= '0;
                end
                if (r_busy[i] && r_qk[i] != '0 && r_qk[i] == bus.cdb_alu_tag) begin
                    r_vk[i] <= bus.cdb_alu_val;
                    r_qk[i] <= '0;
                end else if (r_busy[i] && r_qk[i] != '0 && r_qk[i] == bus.cdb_lsb_tag) begin
                    r_vk[i] <= bus.cdb_lsb_val;
                    r_qk[i] <= '0;
                end
            end
            if (w_accept) begin
                r_vj[w_free_idx] <= w_vj;
                r_vk[w_free_idx] <= w_vk;
                r_qj[w_free_idx] <= w_qj;
                r_qk[w_free_idx] <= w_qk;
            end
        end
    end

    // Registered issue port; a bubble or flush presents an all-zero NOP to the ALU
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_alu_inst <= '0;
            r_alu_npc  <= '0;
            r_alu_rs1  <= '0;
            r_alu_rs2  <= '0;
            r_alu_imme <= '0;
            r_alu_tag  <= '0;
        end else if (rdy_in) begin
            r_alu_inst <= w_go ? r_inst[w_rdy_idx] : '0;
            r_alu_npc  <= w_go ? r_npc[w_rdy_idx]  : '0;
            r_alu_rs1  <= w_go ? r_vj[w_rdy_idx]   : '0;
            r_alu_rs2  <= w_go ? r_vk[w_rdy_idx]   : '0;
            r_alu_imme <= w_go ? r_imme[w_rdy_idx] : '0;
            r_alu_tag  <= w_go ? r_dest[w_rdy_idx] : '0;
        end
    end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb_alu_rs_scheduler: vector table, directed corner sequences and randomized model check for alu_rs_scheduler
module tb_alu_rs_scheduler;
    localparam logic [5:0] ADDI = 6'd19;
    localparam logic [5:0] ADD  = 6'd1;

    logic clk_in   = 1'b0;
    logic rst_in   = 1'b1;
    logic rdy_in   = 1'b1;
    logic clear_in = 1'b0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    alu_rs_scheduler_if #(.TAG_W(4), .INST_W(6), .XLEN(32)) bus ();

    alu_rs_scheduler #(.RS_DEPTH(16), .TAG_W(4), .INST_W(6), .XLEN(32)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        dv;
        logic [5:0]  inst;
        logic [3:0]  dest, qj, qk;
        logic [31:0] vj, vk, imme;
        logic [3:0]  atag;
        logic [31:0] aval;
        logic [3:0]  ltag;
        logic [31:0] lval;
        logic [5:0]  x_inst;
        logic [3:0]  x_tag;
        logic [31:0] x_rs1, x_rs2, x_imme;
    } vec_t;

    typedef struct {
        bit          busy;
        logic [5:0]  inst;
        logic [31:0] npc, imme, vj, vk;
        logic [3:0]  dest, qj, qk;
    } ent_t;

    vec_t        tbl [14];
    ent_t        m [16];
    logic [5:0]  e_inst;
    logic [3:0]  e_tag;
    logic [31:0] e_npc, e_rs1, e_rs2, e_imme;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid  = 1'b0;
        bus.disp_inst   = '0;
        bus.disp_npc    = '0;
        bus.disp_imme   = '0;
        bus.disp_dest   = '0;
        bus.disp_vj     = '0;
        bus.disp_vk     = '0;
        bus.disp_qj     = '0;
        bus.disp_qk     = '0;
        bus.cdb_alu_tag = '0;
        bus.cdb_alu_val = '0;
        bus.cdb_lsb_tag = '0;
        bus.cdb_lsb_val = '0;
    endtask

    task automatic disp(input logic [5:0] inst, input logic [3:0] dest, input logic [3:0] qj,
                        input logic [3:0] qk, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] imme);
        idle();
        bus.disp_valid = 1'b1;
        bus.disp_inst  = inst;
        bus.disp_dest  = dest;
        bus.disp_qj    = qj;
        bus.disp_qk    = qk;
        bus.disp_vj    = vj;
        bus.disp_vk    = vk;
        bus.disp_imme  = imme;
        bus.disp_npc   = imme + 32'd4;
    endtask

    // Reference model: a tag resolves against the ALU bus first, then the load/store bus
    function automatic logic [35:0] snoop(input logic [3:0] q, input logic [31:0] v);
        if (q != 4'd0 && q == bus.cdb_alu_tag) return {4'd0, bus.cdb_alu_val};
        if (q != 4'd0 && q == bus.cdb_lsb_tag) return {4'd0, bus.cdb_lsb_val};
        return {q, v};
    endfunction

    function automatic int occupancy();
        int n = 0;
        foreach (m[i]) n += int'(m[i].busy);
        return n;
    endfunction

    task automatic model_reset();
        foreach (m[i]) m[i].busy = 1'b0;
        {e_inst, e_tag, e_npc, e_rs1, e_rs2, e_imme} = '0;
    endtask

    // One enabled clock of the station: pick oldest-index ready op, wake waiters, accept dispatch
    task automatic model_step();
        int   is = -1;
        int   fr = -1;
        ent_t n;
        if (!rdy_in) return;
        if (clear_in) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 16; i++) begin
            if (is < 0 && m[i].busy && m[i].qj == 4'd0 && m[i].qk == 4'd0) is = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        if (is >= 0) begin
            e_inst = m[is].inst;
            e_tag  = m[is].dest;
            e_npc  = m[is].npc;
            e_rs1  = m[is].vj;
            e_rs2  = m[is].vk;
            e_imme = m[is].imme;
            m[is].busy = 1'b0;
        end else begin
            {e_inst, e_tag, e_npc, e_rs1, e_rs2, e_imme} = '0;
        end
        foreach (m[i]) begin
            if (m[i].busy) begin
                {m[i].qj, m[i].vj} = snoop(m[i].qj, m[i].vj);
                {m[i].qk, m[i].vk} = snoop(m[i].qk, m[i].vk);
            end
        end
        if (bus.disp_valid && fr >= 0) begin
            n.busy = 1'b1;
            n.inst = bus.disp_inst;
            n.npc  = bus.disp_npc;
            n.imme = bus.disp_imme;
            n.dest = bus.disp_dest;
            {n.qj, n.vj} = snoop(bus.disp_qj, bus.disp_vj);
            {n.qk, n.vk} = snoop(bus.disp_qk, bus.disp_vk);
            m[fr] = n;
        end
    endtask

    task automatic check_model();
        chk("rnd_inst", 32'(bus.alu_inst), 32'(e_inst));
        chk("rnd_tag",  32'(bus.alu_tag),  32'(e_tag));
        chk("rnd_npc",  bus.alu_npc,       e_npc);
        chk("rnd_rs1",  bus.alu_rs1_val,   e_rs1);
        chk("rnd_rs2",  bus.alu_rs2_val,   e_rs2);
        chk("rnd_imme", bus.alu_imme,      e_imme);
        chk("rnd_full", 32'(bus.rs_full),  32'(occupancy() == 16));
    endtask

    initial begin
        tbl[0]  = '{1, ADDI, 3, 0, 0, 5, 0, 7,     0, 0,      0, 0,     0,    0, 0,      0,      0};
        tbl[1]  = '{0, 0,    0, 0, 0, 0, 0, 0,     0, 0,      0, 0,     ADDI, 3, 5,      0,      7};
        tbl[2]  = '{0, 0,    0, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,    0, 0,      0,      0};
        tbl[3]  = '{1, ADD,  4, 2, 0, 0, 9, 0,     0, 0,      0, 0,     0,    0, 0,      0,      0};
        tbl[4]  = '{0, 0,    0, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,    0, 0,      0,      0};
        tbl[5]  = '{0, 0,    0, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,    0, 0,      0,      0};
        tbl[6]  = '{0, 0,    0, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,    0, 0,      0,      0};
        tbl[7]  = '{0, 0,    0, 0, 0, 0, 0, 0,     0, 0,      2, 'h10,  0,    0, 0,      0,      0};
        tbl[8]  = '{0, 0,    0, 0, 0, 0, 0, 0,     0, 0,      0, 0,     ADD,  4, 'h10,   9,      0};
        tbl[9]  = '{1, ADD,  6, 5, 0, 0, 1, 0,     5, 'hAB,   0, 0,     0,    0, 0,      0,      0};
        tbl[10] = '{0, 0,    0, 0, 0, 0, 0, 0,     0, 0,      0, 0,     ADD,  6, 'hAB,   1,      0};
        tbl[11] = '{1, ADD,  7, 8, 8, 0, 0, 0,     8, 'h11,   8, 'h22,  0,    0, 0,      0,      0};
        tbl[12] = '{0, 0,    0, 0, 0, 0, 0, 0,     0, 0,      0, 0,     ADD,  7, 'h11,   'h11,   0};
        tbl[13] = '{0, 0,    0, 0, 0, 0, 0, 0,     0, 0,      0, 0,     0,    0, 0,      0,      0};

        idle();
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk("reset_inst", 32'(bus.alu_inst), 32'd0);
        chk("reset_tag",  32'(bus.alu_tag),  32'd0);
        chk("reset_rs1",  bus.alu_rs1_val,   32'd0);
        chk("reset_full", 32'(bus.rs_full),  32'd0);

        // Single-op latency, CDB wakeup, dispatch bypass and ALU-over-LSB priority
        for (int r = 0; r < 14; r++) begin
            if (tbl[r].dv) disp(tbl[r].inst, tbl[r].dest, tbl[r].qj, tbl[r].qk, tbl[r].vj, tbl[r].vk, tbl[r].imme);
            else idle();
            bus.cdb_alu_tag = tbl[r].atag;
            bus.cdb_alu_val = tbl[r].aval;
            bus.cdb_lsb_tag = tbl[r].ltag;
            bus.cdb_lsb_val = tbl[r].lval;
            tick();
            chk($sformatf("vec%0d_inst", r), 32'(bus.alu_inst), 32'(tbl[r].x_inst));
            chk($sformatf("vec%0d_tag", r),  32'(bus.alu_tag),  32'(tbl[r].x_tag));
            chk($sformatf("vec%0d_rs1", r),  bus.alu_rs1_val,   tbl[r].x_rs1);
            chk($sformatf("vec%0d_rs2", r),  bus.alu_rs2_val,   tbl[r].x_rs2);
            chk($sformatf("vec%0d_imme", r), bus.alu_imme,      tbl[r].x_imme);
        end

        // Fill all 16 entries waiting on tag 7, overflow attempt, then in-order drain
        for (int i = 0; i < 16; i++) begin
            disp(ADD, 4'(i), 4'd0, 4'd7, 32'd100 + 32'(i), 32'd0, 32'd0);
            tick();
            chk("fill_full", 32'(bus.rs_full), 32'(i == 15));
            chk("fill_noissue", 32'(bus.alu_inst), 32'd0);
        end
        disp(ADD, 4'd9, 4'd0, 4'd0, 32'd999, 32'd0, 32'd0);
        tick();
        chk("overflow_full", 32'(bus.rs_full), 32'd1);
        chk("overflow_noissue", 32'(bus.alu_inst), 32'd0);
        idle();
        bus.cdb_alu_tag = 4'd7;
        bus.cdb_alu_val = 32'h77;
        tick();
        chk("wake_noissue", 32'(bus.alu_inst), 32'd0);
        chk("wake_full", 32'(bus.rs_full), 32'd1);
        idle();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("drain_inst", 32'(bus.alu_inst), 32'(ADD));
            chk("drain_tag", 32'(bus.alu_tag), 32'(i));
            chk("drain_rs1", bus.alu_rs1_val, 32'd100 + 32'(i));
            chk("drain_rs2", bus.alu_rs2_val, 32'h77);
            chk("drain_full", 32'(bus.rs_full), 32'd0);
        end
        tick();
        chk("drain_done", 32'(bus.alu_inst), 32'd0);

        // Flush with a ready entry pending and a dispatch in the same cycle
        for (int i = 0; i < 3; i++) begin
            disp(ADD, 4'(i + 1), 4'd9, 4'd0, 32'd0, 32'd0, 32'd0);
            tick();
        end
        disp(ADD, 4'd4, 4'd0, 4'd0, 32'h44, 32'd0, 32'd0);
        tick();
        disp(ADD, 4'd5, 4'd0, 4'd0, 32'h55, 32'd0, 32'd0);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        idle();
        chk("clear_inst", 32'(bus.alu_inst), 32'd0);
        chk("clear_tag", 32'(bus.alu_tag), 32'd0);
        chk("clear_full", 32'(bus.rs_full), 32'd0);
        bus.cdb_alu_tag = 4'd9;
        bus.cdb_alu_val = 32'h1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle();
            chk("clear_noissue", 32'(bus.alu_tag), 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            disp(ADD, 4'd1, 4'd10, 4'd0, 32'd0, 32'd0, 32'd0);
            tick();
            chk("refill_full", 32'(bus.rs_full), 32'(i == 15));
        end
        idle();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        chk("reclear_full", 32'(bus.rs_full), 32'd0);

        // rdy_in low freezes everything and drops inputs; async reset acts between edges
        disp(ADDI, 4'd11, 4'd0, 4'd0, 32'hA1, 32'd0, 32'd5);
        tick();
        disp(ADDI, 4'd12, 4'd0, 4'd0, 32'hB2, 32'd0, 32'd6);
        tick();
        chk("hold_pre_tag", 32'(bus.alu_tag), 32'd11);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            disp(ADD, 4'd13, 4'd0, 4'd0, 32'hC0, 32'd0, 32'd0);
            tick();
            chk("hold_tag", 32'(bus.alu_tag), 32'd11);
            chk("hold_rs1", bus.alu_rs1_val, 32'hA1);
            chk("hold_imme", bus.alu_imme, 32'd5);
        end
        rdy_in = 1'b1;
        idle();
        tick();
        chk("resume_tag", 32'(bus.alu_tag), 32'd12);
        chk("resume_rs1", bus.alu_rs1_val, 32'hB2);
        tick();
        chk("resume_dropped", 32'(bus.alu_tag), 32'd0);
        disp(ADD, 4'd14, 4'd0, 4'd0, 32'hC3, 32'd0, 32'd0);
        tick();
        disp(ADD, 4'd15, 4'd3, 4'd0, 32'd0, 32'd0, 32'd0);
        tick();
        idle();
        chk("prerst_tag", 32'(bus.alu_tag), 32'd14);
        #3;
        rst_in = 1'b1;
        #1;
        chk("arst_tag", 32'(bus.alu_tag), 32'd0);
        chk("arst_inst", 32'(bus.alu_inst), 32'd0);
        chk("arst_rs1", bus.alu_rs1_val, 32'd0);
        chk("arst_full", 32'(bus.rs_full), 32'd0);
        #1;
        rst_in = 1'b0;
        bus.cdb_alu_tag = 4'd3;
        tick();
        idle();
        tick();
        chk("arst_after", 32'(bus.alu_tag), 32'd0);

        // Randomized traffic against the reference model
        rst_in = 1'b1;
        model_reset();
        tick();
        rst_in = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rdy_in          = $urandom_range(0, 9) != 0;
            clear_in        = $urandom_range(0, 59) == 0;
            bus.disp_valid  = $urandom_range(0, 2) != 0;
            bus.disp_inst   = 6'($urandom_range(1, 63));
            bus.disp_dest   = 4'($urandom);
            bus.disp_npc    = $urandom;
            bus.disp_imme   = $urandom;
            bus.disp_vj     = $urandom;
            bus.disp_vk     = $urandom;
            bus.disp_qj     = $urandom_range(0, 1) != 0 ? 4'd0 : 4'($urandom_range(1, 3));
            bus.disp_qk     = $urandom_range(0, 1) != 0 ? 4'd0 : 4'($urandom_range(1, 3));
            bus.cdb_alu_tag = 4'($urandom_range(0, 3));
            bus.cdb_alu_val = $urandom;
            bus.cdb_lsb_tag = 4'($urandom_range(0, 3));
            bus.cdb_lsb_val = $urandom;
            model_step();
            tick();
            check_model();
        end
        rdy_in   = 1'b1;
        clear_in = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
